// File: rtl/psmac_acc.sv
// psmac_acc: pipelined precision-scalable (2/4/8-bit) dot-product MAC with vector accumulation.
// Define PSMAC_SAT_EN for a saturating accumulator with an ovf flag; otherwise the accumulator wraps.
module rcbb (
  input  logic              sa,
  input  logic              sb,
  input  logic [1:0]        a,
  input  logic [1:0]        b,
  output logic signed [5:0] p
);
  logic signed [5:0] xa, xb;
  assign xa = 6'($signed({sa & a[1], a}));
  assign xb = 6'($signed({sb & b[1], b}));
  assign p = xa * xb;
endmodule

module psmac_acc #(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [8*LANES-1:0] ip,
  input  logic [8*LANES-1:0] wt,
  input  logic [1:0]         prec,
  input  logic               sgn_x,
  input  logic               sgn_w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               ovf
);
  localparam int BS_W = 17 + $clog2(LANES);
  localparam int ND = 16 * LANES;
  logic stall;
  logic [3:0] fx, fw;
  logic signed [5:0] dp [ND];
  logic signed [5:0] dq [ND];
  logic s1_v, s1_l, s2_v, s2_l;
  logic [1:0] s1_m;
  logic signed [BS_W-1:0] bs, s2_bs;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nsum;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  // Only the top digit of each element carries the sign, so the flag depends on precision.
  for (genvar g = 0; g < 4; g++) begin : g_flag
    assign fx[g] = sgn_x & (prec == 2'b00 || (prec == 2'b01 && g % 2 == 1) || (prec[1] && g == 3));
    assign fw[g] = sgn_w & (prec == 2'b00 || (prec == 2'b01 && g % 2 == 1) || (prec[1] && g == 3));
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar i = 0; i < 4; i++) begin : g_x
      for (genvar j = 0; j < 4; j++) begin : g_w
        rcbb u_d (
          .sa(fx[i]),
          .sb(fw[j]),
          .a (ip[8*l+2*i +: 2]),
          .b (wt[8*l+2*j +: 2]),
          .p (dp[16*l+4*i+j])
        );
      end
    end
  end
  // Weight of digit product (i,j); cross-element pairs drop out in narrow modes.
  function automatic logic signed [BS_W-1:0] term(input logic signed [5:0] p, input logic [1:0] m,
                                                  input int i, input int j);
    logic signed [BS_W-1:0] e;
    e = BS_W'(p);
    if (m[1]) return e <<< (2 * (i + j));
    if (m[0]) return (i / 2 == j / 2) ? e <<< (2 * (i % 2 + j % 2)) : '0;
    return (i == j) ? e : '0;
  endfunction
  always_comb begin
    bs = '0;
    for (int k = 0; k < ND; k++) bs += term(dq[k], s1_m, (k / 4) % 4, k % 4);
  end
  always_ff @(posedge clk) begin
    if (!stall) begin
      dq <= dp;
      s1_l <= in_last;
      s1_m <= prec;
      s2_l <= s1_l;
      s2_bs <= bs;
    end
  end
`ifdef PSMAC_SAT_EN
  localparam int SW = (ACC_W > BS_W ? ACC_W : BS_W) + 1;
  localparam logic signed [SW-1:0] HI = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] LO = ~HI;
  logic signed [SW-1:0] sum;
  logic sat, seen;
  assign sum = SW'(acc) + SW'(s2_bs);
  assign sat = sum > HI || sum < LO;
  assign nsum = sum > HI ? HI[ACC_W-1:0] : sum < LO ? LO[ACC_W-1:0] : sum[ACC_W-1:0];
`else
  assign nsum = acc + ACC_W'(s2_bs);
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      acc <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
`ifdef PSMAC_SAT_EN
      ovf <= 1'b0;
      seen <= 1'b0;
`endif
    end else if (!stall) begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      out_valid <= s2_v & s2_l;
      if (s2_v) begin
        acc <= s2_l ? '0 : nsum;
        if (s2_l) out_data <= nsum;
`ifdef PSMAC_SAT_EN
        seen <= s2_l ? 1'b0 : seen | sat;
        if (s2_l) ovf <= seen | sat;
`endif
      end
    end
  end
endmodule

// File: tb/tb_psmac_acc.sv
// tb_psmac_acc: directed checks of psmac_acc (32-bit and 20-bit accumulator instances share stimulus).
module tb_psmac_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, sgn_x = 1'b0, sgn_w = 1'b0;
  logic [31:0] ip = '0, wt = '0;
  logic [1:0] prec = 2'b00;
  logic in_ready, out_valid, ovf, rdy20, val20, ovf20;
  logic signed [31:0] out_data;
  logic signed [19:0] out20;
  logic signed [19:0] e20;
  logic eovf;
  int ncmp = 0, nfail = 0;
  always #5 clk = ~clk;

  psmac_acc #(.LANES(4), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ip(ip), .wt(wt), .prec(prec), .sgn_x(sgn_x), .sgn_w(sgn_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );
  psmac_acc #(.LANES(4), .ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy20), .in_last(in_last),
    .ip(ip), .wt(wt), .prec(prec), .sgn_x(sgn_x), .sgn_w(sgn_w),
    .out_valid(val20), .out_ready(out_ready), .out_data(out20), .ovf(ovf20)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] x, input logic [31:0] w, input logic [1:0] p,
                      input logic sx, input logic sw, input logic l);
    in_valid = 1'b1; ip = x; wt = w; prec = p; sgn_x = sx; sgn_w = sw; in_last = l;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef PSMAC_SAT_EN
    e20 = 20'sd524287; eovf = 1'b1;
`else
    e20 = -20'sd467932; eovf = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    // 8-bit signed single beat: 4 * (-128)^2
    beat(32'h80808080, 32'h80808080, 2'b10, 1'b1, 1'b1, 1'b1);
    check("t1_in_ready", in_ready, 1);
    tick();
    check("t1_valid_k1", out_valid, 0);
    tick();
    check("t1_valid_k2", out_valid, 1);
    check("t1_data", out_data, 65536);
    tick();
    check("t1_consumed", out_valid, 0);
    check("t1_hold", out_data, 65536);
    // 2-bit unsigned, three beats of 16 * 9
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b0, 1'b0);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b0, 1'b0);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    check("t2_valid_early", out_valid, 0);
    tick();
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 432);
    tick();
    // 4-bit signed x unsigned, then a back-to-back 8-bit unsigned vector
    beat(32'h88888888, 32'hFFFFFFFF, 2'b01, 1'b1, 1'b0, 1'b1);
    beat(32'h01010101, 32'h02020202, 2'b10, 1'b0, 1'b0, 1'b1);
    tick();
    check("t3a_valid", out_valid, 1);
    check("t3a_data", out_data, -960);
    tick();
    check("t3b_valid", out_valid, 1);
    check("t3b_data", out_data, 8);
    tick();
    check("t3_idle", out_valid, 0);
    // backpressure: result 40 pending, partial beat 4 parked in the pipe, last beat 12 waiting
    out_ready = 1'b0;
    beat(32'h02020202, 32'h05050505, 2'b10, 1'b0, 1'b0, 1'b1);
    beat(32'h01010101, 32'h01010101, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b1; ip = 32'h01010101; wt = 32'h03030303; prec = 2'b10;
    sgn_x = 1'b0; sgn_w = 1'b0; in_last = 1'b1;
    for (int n = 0; n < 5; n++) begin
      check("t4_stall_ready", in_ready, 0);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_data", out_data, 40);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_one_transfer", out_valid, 0);
    check("t4_data_hold", out_data, 40);
    tick();
    check("t4_no_dup", out_valid, 0);
    tick();
    check("t4_next_valid", out_valid, 1);
    check("t4_next_data", out_data, 16);
    tick();
    // nine beats of 64516: fits 32 bits, overflows 20 bits
    for (int n = 0; n < 8; n++) beat(32'h7F7F7F7F, 32'h7F7F7F7F, 2'b10, 1'b1, 1'b1, 1'b0);
    beat(32'h7F7F7F7F, 32'h7F7F7F7F, 2'b10, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("t5_valid", out_valid, 1);
    check("t5_data32", out_data, 580644);
    check("t5_ovf32", ovf, 0);
    check("t5_valid20", val20, 1);
    check("t5_data20", out20, e20);
    check("t5_ovf20", ovf20, eovf);
    tick();
    // reset mid-vector, then a fresh single-beat vector of 1x1 on all lanes
    beat(32'h01010101, 32'h01010101, 2'b10, 1'b0, 1'b0, 1'b0);
    beat(32'h01010101, 32'h01010101, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_data", out_data, 0);
    tick();
    beat(32'h01010101, 32'h01010101, 2'b10, 1'b0, 1'b0, 1'b1);
    tick();
    check("t6_valid_early", out_valid, 0);
    tick();
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/psmac_acc.md
# psmac_acc

Parametrised, pipelined precision-scalable dot-product MAC with accumulation. It takes LANES bytes of input activations and LANES bytes of weights per beat. Each byte is treated as one 8-bit element, two 4-bit elements or four 2-bit elements, selectable per beat, and every element is signed or unsigned per operand. Each beat's dot product is accumulated across a vector delimited by `in_last`. This block is the next-generation replacement for the fixed 32-bit single-cycle fused unit. It sits between the operand buffers and the activation/writeback stage.

## Interface
- `LANES`, 4: number of 8-bit lanes per operand; operand width is 8*LANES.
- `ACC_W`, 32: accumulator and result width, two's complement; legal range 20..48.
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: reset; asynchronous, active-high.
- `in_valid` input, 1: beat present.
- `in_ready` output, 1: beat accepted when `in_valid & in_ready`.
- `in_last` input, 1: beat is the final beat of the current vector.
- `ip` input, 8*LANES: activation elements.
- `wt` input, 8*LANES: weight elements.
- `prec` input, 2: element precision. 00 = 2-bit, 01 = 4-bit, 10 = 8-bit. 11 is reserved and treated as 10.
- `sgn_x` input, 1: `ip` elements are signed.
- `sgn_w` input, 1: `wt` elements are signed.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: result consumed when `out_valid & out_ready`.
- `out_data` output, ACC_W: signed vector dot product.
- `ovf` output, 1: result overflowed ACC_W. Only meaningful with `PSMAC_SAT_EN` defined.

## Operation
- **Element packing.** Element e occupies `ip/wt[W*e+W-1 : W*e]`, where W is 2, 4 or 8. Products pair equal indices of `ip` and `wt`. A beat therefore carries 4*LANES, 2*LANES or LANES products.
- **Signedness.** 2-bit signed range is −2..1; unsigned range is 0..3. Wider elements extend this in the obvious way.
- **Multiplier structure.** Products are built from the existing `rcbb` 2b×2b digit multipliers, 16 per lane.
  - Only the most-significant digit of each element carries the sign flag.
  - Digit products are shift-added per the selected precision.
- **Beat sum.** Each beat's products are summed to a signed (17 + ceil(log2 LANES))-bit beat sum. Per-beat sums are exact.
- **Mode changes.** `prec`, `sgn_x` and `sgn_w` are sampled with each beat and travel with it down the pipeline. Mixing modes inside a vector is legal; each beat is computed under its own mode.
- **Pipeline.**
  - S1 registers the digit products, plus valid/last/mode.
  - S2 registers the beat sum.
  - S3 adds the beat sum into `acc`.
- **Vector completion.** When S3 processes a last beat:
  - `out_data` is set to `acc` + beat sum, and `out_valid` is set.
  - `acc` is cleared to 0 on the same edge.
  - The next vector may follow with no bubble.
- **Single-beat vectors.** A beat with `in_last` set on the first beat of a vector produces that beat's sum as the result.
- **Backpressure.**
  - `stall = out_valid & ~out_ready`.
  - While stalled, S1/S2/S3, `acc` and `out_data` all hold, and `in_ready` = 0.
  - Otherwise `in_ready` = 1.
- **Output handshake.**
  - On `out_valid & out_ready`, `out_valid` clears unless a new last beat completes on the same edge; in that case `out_valid` stays 1 and `out_data` updates.
  - `out_data` holds its value while `out_valid` is 0.
- **Reset.** Reset is asynchronous and may occur mid-vector. It clears all stage valids, `acc`, `out_data`, `out_valid` and `ovf` to 0. Beats in flight are discarded.

## Timing
- A beat accepted at edge k updates `acc` at edge k+2 when no stall occurs.
- For a last beat accepted at edge k, `out_valid` = 1 is visible after edge k+2.
- Throughput is one beat per cycle when unstalled.
- `in_ready` is combinational from `out_valid` and `out_ready` only.
- After reset deasserts, `in_ready` = 1 and `out_valid` = 0.

## Configuration
- **`PSMAC_SAT_EN` defined.**
  - The S3 add saturates `acc` and `out_data` to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - `ovf` is set with `out_valid` if any add in that vector saturated, and clears on the next result.
  - Once saturated, later adds in the same vector continue from the clamped value.
- **`PSMAC_SAT_EN` not defined.**
  - The accumulator wraps modulo 2^ACC_W.
  - `ovf` is tied to 0.

## Test plan
- **8-bit signed, single beat.** LANES=4, `prec`=10, `sgn_x`=`sgn_w`=1, `ip`=`wt`=0x80808080, `in_last`=1 → `out_data`=65536, `out_valid` 2 edges after acceptance.
- **2-bit unsigned, three beats.** `prec`=00, `sgn_x`=`sgn_w`=0, `ip`=`wt`=0xFFFFFFFF, 3 beats with last on the 3rd → 432.
- **4-bit mixed signedness, then back-to-back vector.** `prec`=01, `sgn_x`=1, `sgn_w`=0, `ip`=0x88888888, `wt`=0xFFFFFFFF, single beat → −960. A second 1-beat vector in the next cycle yields its own result on the following edge, with no carry-over.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles with a result pending → `in_ready`=0, and `out_data` and `acc` are stable. Releasing `out_ready` gives exactly one transfer and no lost or duplicated result.
- **Saturation versus wrap.** ACC_W=20, 8-bit signed, `ip`=`wt`=0x7F7F7F7F, 9 beats (64516 per beat).
  - With `PSMAC_SAT_EN`: `out_data`=524287, `ovf`=1.
  - Without: `out_data`=580644 mod 2^20 interpreted as signed = −467932, `ovf`=0.
- **Reset mid-vector.** Assert `rst` after 2 of 4 beats, then send a fresh 1-beat vector of 8-bit 1×1 on all lanes → `out_data`=4, with no contribution from the pre-reset beats.
